// File: rtl/u712_cpu_chip_bus.sv
// 68040-side front end for CPU accesses to chip RAM: decodes the transfer start and
// strobes the chip RAM controller, then turns CPU_TACK (or a timeout) into TAn/TBIn/TEAn.
module u712_cpu_chip_bus #(
  parameter int unsigned TA_WIDTH = 2,
  parameter int unsigned TIMEOUT  = 4000,
  parameter bit          CHIP_2MB = 1'b1
) (
  input  logic        CLK80,
  input  logic        RESETn,
  input  logic        TSn,
  input  logic [1:0]  TTn,
  input  logic [11:0] A,
  input  logic [1:0]  SIZ,
  input  logic        RnW,
  input  logic        OVL,
  input  logic        CPU_TACK,
  output logic        CHIP_TSn,
  output logic        RAMSPACEn,
  output logic        TAn,
  output logic        TBIn,
  output logic        TEAn,
  output logic        BUSY
);

  localparam int unsigned TMO_W = 12;
  localparam int unsigned WID_W = (TA_WIDTH > 1) ? $clog2(TA_WIDTH) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [WID_W-1:0] WID_LAST = WID_W'(TA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, ACK, ERR} state_t;

  state_t           state, state_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic [WID_W-1:0] wid_cnt, wid_cnt_d;
  logic             line, line_d;
  logic             chip_ts_n_d, ramspace_n_d, ta_n_d, tbi_n_d, tea_n_d, busy_d;
  logic             hit_c, ovl_rom_c;

  // Direction is consumed by the controller directly; nothing to do with it here.
  logic unused_rnw;
  assign unused_rnw = RnW;

  // A19 is not visible on this port, so the overlay shadow covers the whole low 1MB (A20=0).
  assign ovl_rom_c = OVL && !A[0];
  assign hit_c     = !TSn && (TTn == 2'b00) && (A[11:1] == 11'd0)
                     && (CHIP_2MB || !A[0]) && !ovl_rom_c;

  // State, counters and registered outputs; everything moves on the falling edge.
  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      wid_cnt   <= '0;
      line      <= 1'b0;
      CHIP_TSn  <= 1'b1;
      RAMSPACEn <= 1'b1;
      TAn       <= 1'b1;
      TBIn      <= 1'b1;
      TEAn      <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_d;
      tmo_cnt   <= tmo_cnt_d;
      wid_cnt   <= wid_cnt_d;
      line      <= line_d;
      CHIP_TSn  <= chip_ts_n_d;
      RAMSPACEn <= ramspace_n_d;
      TAn       <= ta_n_d;
      TBIn      <= tbi_n_d;
      TEAn      <= tea_n_d;
      BUSY      <= busy_d;
    end
  end

  // Next state; CPU_TACK beats a coincident timeout.
  always_comb begin
    state_d   = state;
    tmo_cnt_d = tmo_cnt;
    wid_cnt_d = wid_cnt;
    line_d    = line;
    unique case (state)
      IDLE: begin
        if (hit_c) begin
          state_d = START;
          line_d  = (SIZ == 2'b11);
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (tmo_cnt != '1) tmo_cnt_d = tmo_cnt + TMO_W'(1);
        if (CPU_TACK) begin
          state_d   = ACK;
          wid_cnt_d = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d   = ERR;
          wid_cnt_d = '0;
        end
      end
      ACK, ERR: begin
        if (wid_cnt == WID_LAST) state_d = IDLE;
        else                     wid_cnt_d = wid_cnt + WID_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the state being entered, registered on the same edge.
  always_comb begin
    chip_ts_n_d  = 1'b1;
    ramspace_n_d = 1'b1;
    ta_n_d       = 1'b1;
    tbi_n_d      = 1'b1;
    tea_n_d      = 1'b1;
    busy_d       = 1'b0;
    unique case (state_d)
      START: begin
        chip_ts_n_d  = 1'b0;
        ramspace_n_d = 1'b0;
        busy_d       = 1'b1;
      end
      WAIT: begin
        ramspace_n_d = 1'b0;
        busy_d       = 1'b1;
      end
      ACK: begin
        ta_n_d  = 1'b0;
        tbi_n_d = !line_d;
        busy_d  = 1'b1;
      end
      ERR: begin
        tea_n_d = 1'b0;
        busy_d  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_u712_cpu_chip_bus.sv
// Scoreboard bench for u712_cpu_chip_bus: expected terminations are queued per access
// and matched against observed TAn/TEAn pulses by a monitor sampling on CLK80 rising edges.
module tb_u712_cpu_chip_bus;

  localparam int unsigned TA_W = 2;
  localparam int unsigned TMO  = 4000;

  typedef struct {
    bit          err;
    bit          tbi;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b1;
  logic        rst_n, ts_n, rnw, ovl, cpu_tack;
  logic [1:0]  ttn, siz;
  logic [11:0] a;
  logic        chip_ts_n, ramspace_n, ta_n, tbi_n, tea_n, busy;
  logic        chip_ts_n2, ramspace_n2, ta_n2, tbi_n2, tea_n2, busy2;

  exp_t        sb[$];
  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0, strobes = 0, strobe_long = 0, overlap = 0, terms = 0, d2_act = 0;
  int unsigned strobe_cyc = 0, ram_cnt = 0, term_w = 0;
  bit          in_term = 1'b0, prev_ts = 1'b1;

  always #6 clk = ~clk;

  u712_cpu_chip_bus #(.TA_WIDTH(TA_W), .TIMEOUT(TMO), .CHIP_2MB(1'b1)) dut (
    .CLK80(clk), .RESETn(rst_n), .TSn(ts_n), .TTn(ttn), .A(a), .SIZ(siz), .RnW(rnw),
    .OVL(ovl), .CPU_TACK(cpu_tack), .CHIP_TSn(chip_ts_n), .RAMSPACEn(ramspace_n),
    .TAn(ta_n), .TBIn(tbi_n), .TEAn(tea_n), .BUSY(busy)
  );

  u712_cpu_chip_bus #(.TA_WIDTH(TA_W), .TIMEOUT(TMO), .CHIP_2MB(1'b0)) dut_1m (
    .CLK80(clk), .RESETn(rst_n), .TSn(ts_n), .TTn(ttn), .A(a), .SIZ(siz), .RnW(rnw),
    .OVL(ovl), .CPU_TACK(cpu_tack), .CHIP_TSn(chip_ts_n2), .RAMSPACEn(ramspace_n2),
    .TAn(ta_n2), .TBIn(tbi_n2), .TEAn(tea_n2), .BUSY(busy2)
  );

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) cyc++;

  // Monitor: strobe/RAMSPACEn bookkeeping and termination matching against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_term = 1'b0;
      prev_ts = 1'b1;
    end else begin
      if (!ta_n && !tea_n) overlap++;
      if (!chip_ts_n2 || !ramspace_n2 || !ta_n2 || !tbi_n2 || !tea_n2 || busy2) d2_act++;
      if (!chip_ts_n) begin
        if (!prev_ts) strobe_long++;
        else begin
          strobes++;
          strobe_cyc = cyc;
          ram_cnt    = 0;
        end
      end
      prev_ts = chip_ts_n;
      if (!ramspace_n) ram_cnt++;
      if (!ta_n || !tea_n) begin
        if (!in_term) begin
          in_term = 1'b1;
          term_w  = 0;
          terms++;
          if (sb.size() == 0) check_val("unexpected_term", 1, 0);
          else begin
            e = sb.pop_front();
            check_val("term_is_err", !tea_n, e.err);
            check_val("term_latency", cyc - strobe_cyc, e.lat);
            check_val("ramspace_len", ram_cnt, e.lat);
            check_val("tbi_level", tbi_n, e.tbi);
          end
        end
        term_w++;
      end else if (in_term) begin
        in_term = 1'b0;
        check_val("term_width", term_w, TA_W);
        check_val("busy_at_end", busy, 0);
      end
    end
  end

  // One decoded access; tack_d<0 means no CPU_TACK (timeout), dup_at re-asserts TSn in WAIT.
  task automatic access(input logic [11:0] addr, input logic [1:0] sz, input logic ov,
                        input int tack_d, input int dup_at);
    exp_t        e;
    int unsigned s0;
    int          n;
    e.err = (tack_d < 0);
    e.lat = (tack_d < 0) ? TMO + 1 : 32'(tack_d + 1);
    e.tbi = !(tack_d >= 0 && sz == 2'b11);
    sb.push_back(e);
    s0 = strobes;
    @(negedge clk); #1;
    ts_n = 1'b0; ttn = 2'b00; a = addr; siz = sz; ovl = ov;
    @(negedge clk); #1;
    ts_n = 1'b1;
    @(posedge clk);
    check_val("strobe_latency", chip_ts_n, 0);
    if (tack_d >= 0) begin
      for (int i = 1; i <= tack_d; i++) begin
        @(negedge clk); #1;
        ts_n     = (i == dup_at) ? 1'b0 : 1'b1;
        cpu_tack = (i == tack_d);
      end
      @(negedge clk); #1;
      ts_n = 1'b1; cpu_tack = 1'b0;
    end
    n = 0;
    while (busy && n < 6000) begin
      @(posedge clk);
      n++;
    end
    check_val("access_done", 32'(n < 6000), 1);
    check_val("strobe_count", strobes - s0, 1);
  endtask

  task automatic miss(input string tag, input logic [11:0] addr, input logic [1:0] tt,
                      input logic ov);
    int unsigned act = 0;
    @(negedge clk); #1;
    ts_n = 1'b0; ttn = tt; a = addr; ovl = ov; siz = 2'b00;
    @(negedge clk); #1;
    ts_n = 1'b1; ttn = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (!chip_ts_n || !ramspace_n || busy) act++;
    end
    check_val(tag, act, 0);
  endtask

  initial begin
    int unsigned d0, t0;
    rst_n = 1'b1; ts_n = 1'b1; ttn = 2'b00; a = '0; siz = 2'b00;
    rnw = 1'b1; ovl = 1'b0; cpu_tack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_chip_ts_n", chip_ts_n, 1);
    check_val("rst_ramspace_n", ramspace_n, 1);
    check_val("rst_ta_n", ta_n, 1);
    check_val("rst_tbi_n", tbi_n, 1);
    check_val("rst_tea_n", tea_n, 1);
    check_val("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Longword read, CPU_TACK 9 clocks after the strobe; 1MB variant also hits at A20=0.
    d0 = d2_act;
    access(12'h001, 2'b00, 1'b0, 9, -1);
    check_val("d1m_ignores_a20", d2_act - d0, 0);
    d0 = d2_act;
    access(12'h000, 2'b00, 1'b0, 9, -1);
    check_val("d1m_hits_low", 32'(d2_act > d0), 1);

    // Line write at the top megabyte: TAn+TBIn on the 2MB part, nothing on the 1MB part.
    rnw = 1'b0;
    d0 = d2_act;
    access(12'h001, 2'b11, 1'b0, 4, -1);
    check_val("d1m_line_miss", d2_act - d0, 0);
    rnw = 1'b1;

    miss("miss_a21", 12'h002, 2'b00, 1'b0);
    miss("miss_ttn01", 12'h000, 2'b01, 1'b0);
    miss("miss_ovl_rom", 12'h000, 2'b00, 1'b1);
    access(12'h001, 2'b00, 1'b1, 3, -1);

    access(12'h000, 2'b00, 1'b0, -1, -1);
    access(12'h000, 2'b00, 1'b0, TMO, -1);

    // Second TSn during WAIT, then a stray CPU_TACK while idle.
    access(12'h000, 2'b00, 1'b0, 6, 2);
    t0 = terms;
    @(negedge clk); #1 cpu_tack = 1'b1;
    @(negedge clk); #1 cpu_tack = 1'b0;
    repeat (10) @(posedge clk);
    check_val("stray_tack_term", terms - t0, 0);

    // Reset asserted mid-ACK on a line transfer.
    sb.push_back('{err: 1'b0, tbi: 1'b0, lat: 4});
    @(negedge clk); #1;
    ts_n = 1'b0; ttn = 2'b00; a = 12'h000; siz = 2'b11; ovl = 1'b0;
    @(negedge clk); #1 ts_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1 cpu_tack = (i == 3);
    end
    @(negedge clk); #1 cpu_tack = 1'b0;
    @(posedge clk);
    check_val("pre_rst_ta_n", ta_n, 0);
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_ta_n", ta_n, 1);
    check_val("midrst_tbi_n", tbi_n, 1);
    check_val("midrst_ramspace_n", ramspace_n, 1);
    check_val("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    t0 = terms;
    repeat (20) @(posedge clk);
    check_val("post_rst_term", terms - t0, 0);
    access(12'h000, 2'b00, 1'b0, 5, -1);

    repeat (4) @(posedge clk);
    check_val("sb_empty", sb.size(), 0);
    check_val("ta_tea_overlap", overlap, 0);
    check_val("strobe_too_long", strobe_long, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
